// File: rtl/status_pkg.sv
// NZCV flag register shared definitions.
// Also imported by the condition checker.
package status_pkg;

  localparam int Z_BIT = 3;
  localparam int C_BIT = 2;
  localparam int N_BIT = 1;
  localparam int V_BIT = 0;

  typedef logic [3:0] nzcv_t;

  localparam nzcv_t NZCV_RST = 4'b0000;

  // Builds a flag word in {Z,C,N,V} order.
  function automatic nzcv_t mk_nzcv(
    input logic n,
    input logic z,
    input logic c,
    input logic v
  );
    nzcv_t f;
    f        = NZCV_RST;
    f[Z_BIT] = z;
    f[C_BIT] = c;
    f[N_BIT] = n;
    f[V_BIT] = v;
    return f;
  endfunction

endpackage

// File: rtl/status_register_if.sv
// Request/response bundle of the flag register.
// master drives requests, slave is the register.
interface status_register_if
  import status_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
);

  logic          stall;
  logic          s_en;
  nzcv_t         alu_flags;
  logic          msr_we;
  nzcv_t         msr_data;
  logic          push;
  logic          pop;
  logic          err_clr;
  nzcv_t         status;
  logic [CW-1:0] depth_cnt;
  logic          full;
  logic          empty;
  logic          ovf_err;
  logic          unf_err;
  logic          pp_err;

  modport master (
    output stall, s_en, alu_flags,
    output msr_we, msr_data,
    output push, pop, err_clr,
    input  status, depth_cnt,
    input  full, empty,
    input  ovf_err, unf_err, pp_err
  );

  modport slave (
    input  stall, s_en, alu_flags,
    input  msr_we, msr_data,
    input  push, pop, err_clr,
    output status, depth_cnt,
    output full, empty,
    output ovf_err, unf_err, pp_err
  );

endinterface

// File: rtl/status_stack.sv
// LIFO of saved flag words for exception entry/return.
// Entries are not cleared on reset; only the count is.
module status_stack
  import status_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_en,
  input  logic          pop_en,
  input  nzcv_t         din,
  output nzcv_t         top,
  output logic [CW-1:0] depth_cnt,
  output logic          full,
  output logic          empty
);

  nzcv_t         mem [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx    = AW'(cnt_q);
  assign rd_idx    = AW'(cnt_q - 1'b1);
  assign top       = mem[rd_idx];
  assign depth_cnt = cnt_q;
  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);

  // Occupancy count; enables are pre-qualified by the caller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push_en) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (pop_en) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Entry storage, written at the current count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/status_register.sv
// NZCV flag register with save/restore stack.
// STATUS_FWD_EN: forward pending flag update onto status.
module status_register
  import status_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  status_register_if.slave  bus
);

  nzcv_t flags_q;
  nzcv_t flags_d;
  nzcv_t stk_top;
  logic  stk_full;
  logic  stk_empty;
  logic  act;
  logic  both;
  logic  push_req;
  logic  pop_req;
  logic  restore;
  logic  push_en;
  logic  pop_en;
  logic  ovf_set;
  logic  unf_set;
  logic  pp_set;
  logic  ovf_q;
  logic  unf_q;
  logic  pp_q;

  assign act      = !bus.stall;
  assign both     = bus.push && bus.pop;
  assign push_req = bus.push && !bus.pop;
  assign pop_req  = bus.pop && !bus.push;
  assign restore  = pop_req && !stk_empty;

  assign push_en = rst_n && act && push_req && !stk_full;
  assign pop_en  = rst_n && act && restore;

  assign ovf_set = act && push_req && stk_full;
  assign unf_set = act && pop_req && stk_empty;
  assign pp_set  = act && both;

  // Flag source priority: restore, direct write, ALU.
  always_comb begin
    flags_d = flags_q;
    if (restore) begin
      flags_d = stk_top;
    end else if (bus.msr_we) begin
      flags_d = bus.msr_data;
    end else if (bus.s_en) begin
      flags_d = bus.alu_flags;
    end
  end

  // Architectural flags, frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= NZCV_RST;
    end else if (act) begin
      flags_q <= flags_d;
    end
  end

  // Sticky error bits; a new error beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      pp_q  <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !bus.err_clr) || ovf_set;
      unf_q <= (unf_q && !bus.err_clr) || unf_set;
      pp_q  <= (pp_q && !bus.err_clr) || pp_set;
    end
  end

  status_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_en   (push_en),
    .pop_en    (pop_en),
    .din       (flags_d),
    .top       (stk_top),
    .depth_cnt (bus.depth_cnt),
    .full      (stk_full),
    .empty     (stk_empty)
  );

`ifdef STATUS_FWD_EN
  assign bus.status = act ? flags_d : flags_q;
`else
  assign bus.status = flags_q;
`endif

  assign bus.full    = stk_full;
  assign bus.empty   = stk_empty;
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;
  assign bus.pp_err  = pp_q;

endmodule

// File: tb/tb_status_register.sv
// Directed bench for status_register (registered status build).
// Expected values are hand-computed per step.
module tb_status_register;
  import status_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  status_register_if #(.DEPTH(DEPTH)) bus ();

  status_register #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.stall     = 1'b0;
    bus.s_en      = 1'b0;
    bus.alu_flags = 4'b0000;
    bus.msr_we    = 1'b0;
    bus.msr_data  = 4'b0000;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  // Apply current inputs for one edge, then return to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
  endtask

  task automatic errs(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, bus.ovf_err, bus.unf_err, bus.pp_err},
          {29'd0, exp});
  endtask

  nzcv_t pv [4];

  initial begin
    pv[0] = 4'b0001;
    pv[1] = 4'b0010;
    pv[2] = 4'b0100;
    pv[3] = 4'b1000;
    idle();
    rst_n = 1'b0;
    step();
    check("rst_status", bus.status, 4'b0000);
    check("rst_depth", bus.depth_cnt, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    errs("rst_errs", 3'b000);

    bus.s_en = 1'b1;
    bus.alu_flags = 4'b1010;
    step();
    check("alu_write", bus.status, 4'b1010);

    bus.msr_we = 1'b1;
    bus.msr_data = 4'b0011;
    step();
    check("msr_0011", bus.status, 4'b0011);
    bus.push = 1'b1;
    step();
    check("push1_depth", bus.depth_cnt, 1);
    check("push1_status", bus.status, 4'b0011);
    bus.msr_we = 1'b1;
    bus.msr_data = 4'b1100;
    step();
    check("msr_1100", bus.status, 4'b1100);
    check("msr_depth", bus.depth_cnt, 1);
    bus.pop = 1'b1;
    step();
    check("pop_restore", bus.status, 4'b0011);
    check("pop_depth", bus.depth_cnt, 0);

    for (int i = 0; i < 4; i++) begin
      bus.push = 1'b1;
      bus.msr_we = 1'b1;
      bus.msr_data = pv[i];
      step();
      check($sformatf("fill%0d_depth", i), bus.depth_cnt, i + 1);
      check($sformatf("fill%0d_full", i), bus.full, (i == 3) ? 1 : 0);
    end
    bus.push = 1'b1;
    bus.msr_we = 1'b1;
    bus.msr_data = 4'b1111;
    step();
    check("ovf_depth", bus.depth_cnt, 4);
    check("ovf_status", bus.status, 4'b1111);
    errs("ovf_errs", 3'b100);
    for (int i = 3; i >= 0; i--) begin
      bus.pop = 1'b1;
      step();
      check($sformatf("drain%0d_status", i), bus.status, pv[i]);
      check($sformatf("drain%0d_depth", i), bus.depth_cnt, i);
    end
    check("drain_empty", bus.empty, 1);

    bus.pop = 1'b1;
    bus.s_en = 1'b1;
    bus.alu_flags = 4'b0101;
    step();
    check("unf_status", bus.status, 4'b0101);
    errs("unf_errs", 3'b110);
    bus.err_clr = 1'b1;
    bus.pop = 1'b1;
    step();
    errs("clr_vs_set", 3'b010);
    bus.err_clr = 1'b1;
    step();
    errs("clr_errs", 3'b000);

    bus.push = 1'b1;
    step();
    bus.push = 1'b1;
    step();
    check("two_depth", bus.depth_cnt, 2);
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.s_en = 1'b1;
    bus.alu_flags = 4'b1001;
    step();
    check("pp_depth", bus.depth_cnt, 2);
    check("pp_status", bus.status, 4'b1001);
    errs("pp_errs", 3'b001);
    bus.stall = 1'b1;
    bus.s_en = 1'b1;
    bus.alu_flags = 4'b0110;
    bus.push = 1'b1;
    step();
    check("stall_status", bus.status, 4'b1001);
    check("stall_depth", bus.depth_cnt, 2);
    bus.stall = 1'b1;
    bus.pop = 1'b1;
    step();
    check("stall_pop", bus.depth_cnt, 2);
    errs("stall_errs", 3'b001);

    bus.push = 1'b1;
    step();
    check("three_depth", bus.depth_cnt, 3);
    rst_n = 1'b0;
    bus.push = 1'b1;
    bus.s_en = 1'b1;
    bus.alu_flags = 4'b1111;
    step();
    check("rst2_depth", bus.depth_cnt, 0);
    check("rst2_status", bus.status, 4'b0000);
    check("rst2_empty", bus.empty, 1);
    errs("rst2_errs", 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
